if_fetch: RTL and testbench



---
 rtl/if_fetch_if.sv | 36 +++
 rtl/if_fetch.sv | 174 +++++++++++++++++
 tb/tb_if_fetch.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : if_fetch_if
// Description : Instruction-memory request/response bundle between the fetch
//               stage (master) and instruction memory (slave).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface if_fetch_if;
    logic                   imem_req_o;
    logic [31:0]            imem_addr_o;
    logic                   imem_ready_i;
    logic                   imem_rvalid_i;
    logic [`DATA_WIDTH-1:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ready_i,
        input  imem_rvalid_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ready_i,
        output imem_rvalid_i,
        output imem_rdata_i
    );
endinterface

`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : if_fetch
// Description : RISC-V instruction-fetch stage. Owns the PC, issues word
//               fetches under a credit limit, buffers returned words with
//               their addresses and presents the buffer head to decode.
//               Handles decode stall and branch/jump redirect (flush).
//               Optional feature macro: IF_MISALIGN_CHECK_EN (misaligned
//               redirect target raises exc_misalign_o and halts fetching).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module if_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  wire                    clk,
    input  wire                    rst,
    input  wire                    stall_i,
    input  wire                    flush_i,
    input  wire [31:0]             flush_pc_i,
    if_fetch_if.master             imem,
    output logic                   inst_valid_o,
    output logic [`DATA_WIDTH-1:0] inst_o,
    output logic [31:0]            inst_addr_o
`ifdef IF_MISALIGN_CHECK_EN
    ,
    output logic                   exc_misalign_o
`endif
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_CNT_W:0]       c_DEPTH = (c_CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [`DATA_WIDTH-1:0] c_NOP   = `DATA_WIDTH'(32'h0000_0013);

    logic [31:0]            r_pc;
    logic [c_CNT_W-1:0]     r_outstanding;
    logic [c_CNT_W-1:0]     r_drop;
    logic [c_CNT_W-1:0]     r_count;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_aq_rd;
    logic [c_PTR_W-1:0]     r_aq_wr;
    logic [31:0]            r_addr_hold;
    logic [31:0]            r_fifo_addr [FIFO_DEPTH];
    logic [`DATA_WIDTH-1:0] r_fifo_inst [FIFO_DEPTH];
    logic [31:0]            r_aq_addr   [FIFO_DEPTH];

    logic [31:0]            w_flush_pc;
    logic                   w_fetch_en;
    logic                   w_valid;
    logic                   w_pop;
    logic [c_CNT_W:0]       w_credit;
    logic                   w_req;
    logic                   w_accept;
    logic                   w_resp;
    logic                   w_drop_resp;
    logic                   w_push;

`ifdef IF_MISALIGN_CHECK_EN
    logic                   r_exc;

    assign w_flush_pc     = flush_pc_i;
    assign w_fetch_en     = !r_exc;
    assign exc_misalign_o = r_exc;
`else
    // Without the check, the low address bits of a redirect are forced to 00.
    assign w_flush_pc     = flush_pc_i & 32'hFFFF_FFFC;
    assign w_fetch_en     = 1'b1;
`endif

    // Handshake decode: pop, credit-limited issue, response steering.
    always_comb begin
        w_valid     = (r_count != '0);
        w_pop       = w_valid && !stall_i && !flush_i;
        // Slots already claimed by in-flight fetches plus buffered words,
        // less the one leaving this cycle, must stay below the buffer size.
        w_credit    = {1'b0, r_outstanding} + {1'b0, r_count} - {{c_CNT_W{1'b0}}, w_pop};
        w_req       = rst && !flush_i && w_fetch_en && (w_credit < c_DEPTH);
        w_accept    = w_req && imem.imem_ready_i;
        // Responses with nothing outstanding (e.g. left over across a reset) are ignored.
        w_resp      = rst && imem.imem_rvalid_i && (r_outstanding != '0);
        w_drop_resp = w_resp && (r_drop != '0);
        w_push      = w_resp && !w_drop_resp && !flush_i;
    end

    assign imem.imem_req_o  = w_req;
    assign imem.imem_addr_o = r_pc;

    // Decode-side view of the buffer head; address holds when the buffer is empty.
    always_comb begin
        inst_valid_o = w_valid;
        inst_o       = c_NOP;
        inst_addr_o  = r_addr_hold;
        if (w_valid) begin
            inst_o      = r_fifo_inst[r_rd_ptr];
            inst_addr_o = r_fifo_addr[r_rd_ptr];
        end
    end

    // PC, credit/drop counters and buffer/queue pointers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_aq_rd       <= '0;
            r_aq_wr       <= '0;
`ifdef IF_MISALIGN_CHECK_EN
            r_exc         <= 1'b0;
`endif
        end else if (flush_i) begin
            // Every fetch still outstanding after this cycle's response is stale.
            r_pc          <= w_flush_pc;
            r_outstanding <= r_outstanding - c_CNT_W'(w_resp);
            r_drop        <= r_outstanding - c_CNT_W'(w_resp);
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_aq_rd       <= '0;
            r_aq_wr       <= '0;
`ifdef IF_MISALIGN_CHECK_EN
            r_exc         <= (flush_pc_i[1:0] != 2'b00);
`endif
        end else begin
            if (w_accept) begin
                r_pc    <= r_pc + 32'd4;
                r_aq_wr <= r_aq_wr + c_PTR_W'(1);
            end
            r_outstanding <= r_outstanding + c_CNT_W'(w_accept) - c_CNT_W'(w_resp);
            if (w_drop_resp) begin
                r_drop <= r_drop - c_CNT_W'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                r_aq_rd  <= r_aq_rd + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

    // Storage for in-flight addresses and returned {addr, inst} pairs.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_aq_addr[r_aq_wr] <= r_pc;
        end
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= r_aq_addr[r_aq_rd];
            r_fifo_inst[r_wr_ptr] <= imem.imem_rdata_i;
        end
    end

    // Remember the last presented address so it holds while the buffer is empty.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_addr_hold <= 32'h0000_0000;
        end else begin
            r_addr_hold <= inst_addr_o;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_if_fetch
// Description : Self-checking bench for if_fetch: cycle table for the basic
//               stream/stall/flush behaviour, plus sequences for slow memory,
//               flush with two fetches in flight, misaligned redirect and
//               mid-run reset. A scoreboard tracks every accepted fetch.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_if_fetch;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          FIFO_DEPTH = 2;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   stall = 1'b0;
    logic                   flush = 1'b0;
    logic [31:0]            flush_pc = 32'h0;
    logic                   inst_valid;
    logic [`DATA_WIDTH-1:0] inst;
    logic [31:0]            inst_addr;
`ifdef IF_MISALIGN_CHECK_EN
    logic                   exc;
`endif

    if_fetch_if bus ();

    if_fetch #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall),
        .flush_i      (flush),
        .flush_pc_i   (flush_pc),
        .imem         (bus),
        .inst_valid_o (inst_valid),
        .inst_o       (inst),
        .inst_addr_o  (inst_addr)
`ifdef IF_MISALIGN_CHECK_EN
        ,
        .exc_misalign_o (exc)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        logic        stall;
        logic        flush;
        logic [31:0] fpc;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] iaddr;
    } vec_t;

    exp_t        sb[$];
    pend_t       pend[$];
    vec_t        vt[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          ready_period = 1;
    int          latency = 1;
    int          inflight = 0;
    int          n_pops = 0;
    logic [31:0] tb_pc = RESET_PC;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_5A00;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic add(input logic s, input logic f, input logic [31:0] fpc,
                       input logic r, input logic [31:0] a, input logic v, input logic [31:0] ia);
        vec_t e;
        e.stall = s; e.flush = f; e.fpc = fpc;
        e.req = r; e.addr = a; e.valid = v; e.iaddr = ia;
        vt.push_back(e);
    endtask

    // Scoreboard/memory bookkeeping for the current cycle (called before the edge).
    task automatic sample();
        exp_t e;
        if (rst) begin
            if (inst_valid && !stall && !flush) begin
                n_pops++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_unexpected: got addr %h expected none (cycle %0d)", inst_addr, cyc);
                end else begin
                    e = sb.pop_front();
                    check("sb_addr", inst_addr, e.addr);
                    check("sb_inst", inst, e.data);
                end
            end
            if (flush) begin
                check("req_in_flush", {31'b0, bus.imem_req_o}, 32'd0);
                sb.delete();
`ifdef IF_MISALIGN_CHECK_EN
                tb_pc = (flush_pc[1:0] != 2'b00) ? 32'hFFFF_FFF0 : flush_pc;
`else
                tb_pc = {flush_pc[31:2], 2'b00};
`endif
            end
            if (bus.imem_req_o && bus.imem_ready_i) begin
                check("req_addr", bus.imem_addr_o, tb_pc);
                sb.push_back('{addr: tb_pc, data: mem_word(tb_pc)});
                pend.push_back('{addr: bus.imem_addr_o, due: cyc + latency});
                tb_pc = tb_pc + 32'd4;
                inflight++;
                check("inflight_le_depth", (inflight <= FIFO_DEPTH) ? 32'd1 : 32'd0, 32'd1);
            end
            if (bus.imem_rvalid_i) begin
                inflight--;
            end
        end
    endtask

    // Clock edge, then the memory model drives this cycle's response and ready.
    task automatic advance();
        pend_t p;
        @(posedge clk);
        #1;
        cyc++;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = '0;
        if (!rst) begin
            pend.delete();
            sb.delete();
            inflight = 0;
            tb_pc    = RESET_PC;
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            p = pend.pop_front();
            bus.imem_rvalid_i = 1'b1;
            bus.imem_rdata_i  = mem_word(p.addr);
        end
        bus.imem_ready_i = ((cyc % ready_period) == 0);
    endtask

    task automatic tick();
        #3;
        sample();
        advance();
    endtask

    // Leaves the bench at the sample point of the cycle where inst_valid is seen.
    task automatic wait_valid(input string name, input int budget);
        bit found = 0;
        for (int i = 0; i < budget; i++) begin
            #3;
            if (inst_valid) begin
                found = 1;
                break;
            end
            sample();
            advance();
        end
        if (!found) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got no valid instruction expected one within %0d cycles", name, budget);
            #3;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.imem_ready_i  = 1'b1;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = '0;

        // Reset state
        rst = 1'b0;
        advance();
        for (int i = 0; i < 2; i++) begin
            #3;
            check("rst_req", {31'b0, bus.imem_req_o}, 32'd0);
            check("rst_valid", {31'b0, inst_valid}, 32'd0);
            check("rst_inst", inst, NOP);
            check("rst_iaddr", inst_addr, 32'd0);
`ifdef IF_MISALIGN_CHECK_EN
            check("rst_exc", {31'b0, exc}, 32'd0);
`endif
            sample();
            advance();
        end

        // Cycle table: 1-cycle memory, always ready, from reset release.
        add(0, 0, 32'h0,   1, 32'h000, 0, 32'h000);
        add(0, 0, 32'h0,   1, 32'h004, 0, 32'h000);
        add(0, 0, 32'h0,   1, 32'h008, 1, 32'h000);
        add(0, 0, 32'h0,   1, 32'h00C, 1, 32'h004);
        for (int i = 0; i < 5; i++) add(1, 0, 32'h0, 0, 32'h010, 1, 32'h008);
        add(0, 0, 32'h0,   1, 32'h010, 1, 32'h008);
        add(0, 0, 32'h0,   1, 32'h014, 1, 32'h00C);
        add(0, 0, 32'h0,   1, 32'h018, 1, 32'h010);
        add(0, 1, 32'h100, 0, 32'h01C, 1, 32'h014);
        add(0, 0, 32'h0,   1, 32'h100, 0, 32'h014);
        add(0, 0, 32'h0,   1, 32'h104, 0, 32'h014);
        add(0, 0, 32'h0,   1, 32'h108, 1, 32'h100);
        add(0, 0, 32'h0,   1, 32'h10C, 1, 32'h104);
        add(1, 0, 32'h0,   0, 32'h110, 1, 32'h108);
        add(1, 1, 32'h040, 0, 32'h110, 1, 32'h108);
        add(0, 0, 32'h0,   1, 32'h040, 0, 32'h108);
        add(0, 0, 32'h0,   1, 32'h044, 0, 32'h108);
        add(0, 0, 32'h0,   1, 32'h048, 1, 32'h040);
`ifndef IF_MISALIGN_CHECK_EN
        add(0, 1, 32'h202, 0, 32'h04C, 1, 32'h044);
        add(0, 0, 32'h0,   1, 32'h200, 0, 32'h044);
        add(0, 0, 32'h0,   1, 32'h204, 0, 32'h044);
        add(0, 0, 32'h0,   1, 32'h208, 1, 32'h200);
`endif

        rst = 1'b1;
        for (int i = 0; i < vt.size(); i++) begin
            stall    = vt[i].stall;
            flush    = vt[i].flush;
            flush_pc = vt[i].fpc;
            #3;
            check($sformatf("t%0d_req", i),   {31'b0, bus.imem_req_o}, {31'b0, vt[i].req});
            check($sformatf("t%0d_addr", i),  bus.imem_addr_o, vt[i].addr);
            check($sformatf("t%0d_valid", i), {31'b0, inst_valid}, {31'b0, vt[i].valid});
            check($sformatf("t%0d_iaddr", i), inst_addr, vt[i].iaddr);
            check($sformatf("t%0d_inst", i),  inst, vt[i].valid ? mem_word(vt[i].iaddr) : NOP);
            sample();
            advance();
        end
        stall = 1'b0;
        flush = 1'b0;

        // Slow memory: ready every 3rd cycle, 2-cycle latency, random stalls.
        ready_period = 3;
        latency      = 2;
        n_pops       = 0;
        for (int i = 0; i < 45; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            tick();
        end
        stall = 1'b0;
        check("slow_progress", (n_pops >= 8) ? 32'd1 : 32'd0, 32'd1);

        // Flush with two fetches in flight.
        ready_period = 1;
        begin
            bit got2 = 0;
            for (int i = 0; i < 20; i++) begin
                if (inflight == 2) begin
                    got2 = 1;
                    break;
                end
                tick();
            end
            check("two_in_flight", inflight, 32'd2);
        end
        flush    = 1'b1;
        flush_pc = 32'h100;
        tick();
        flush = 1'b0;
        wait_valid("flush2_wait", 20);
        check("flush2_iaddr", inst_addr, 32'h100);
        check("flush2_inst", inst, mem_word(32'h100));
        sample();
        advance();
        for (int i = 0; i < 6; i++) tick();

`ifdef IF_MISALIGN_CHECK_EN
        // Misaligned redirect halts fetching until an aligned redirect.
        flush    = 1'b1;
        flush_pc = 32'h102;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #3;
            check("mis_exc", {31'b0, exc}, 32'd1);
            check("mis_req", {31'b0, bus.imem_req_o}, 32'd0);
            check("mis_valid", {31'b0, inst_valid}, 32'd0);
            sample();
            advance();
        end
        flush    = 1'b1;
        flush_pc = 32'h200;
        tick();
        flush = 1'b0;
        #3;
        check("mis_clr_exc", {31'b0, exc}, 32'd0);
        check("mis_resume_req", {31'b0, bus.imem_req_o}, 32'd1);
        check("mis_resume_addr", bus.imem_addr_o, 32'h200);
        sample();
        advance();
        wait_valid("mis_wait", 20);
        check("mis_iaddr", inst_addr, 32'h200);
        sample();
        advance();
`endif

        // Reset asserted mid-stream.
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;
        tick();
        latency = 1;
        #3;
        check("mid_rst_req", {31'b0, bus.imem_req_o}, 32'd0);
        check("mid_rst_valid", {31'b0, inst_valid}, 32'd0);
        check("mid_rst_inst", inst, NOP);
        check("mid_rst_iaddr", inst_addr, 32'd0);
        sample();
        advance();
        rst = 1'b1;
        #3;
        check("rel_req", {31'b0, bus.imem_req_o}, 32'd1);
        check("rel_addr", bus.imem_addr_o, RESET_PC);
        sample();
        advance();
        tick();
        #3;
        check("rel_valid", {31'b0, inst_valid}, 32'd1);
        check("rel_iaddr", inst_addr, RESET_PC);
        sample();
        advance();
        for (int i = 0; i < 4; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
